key_conditioner: RTL and testbench
==================================

# key_conditioner

Input stage for the Tetris game controller: it turns five raw, asynchronous push-button levels into clean single-cycle command pulses. Those pulses drive the controller's rotate/left/right/down/start inputs. Per key, the block synchronises, debounces and edge-detects the button. Left/right/down also auto-repeat while held. Pulses that arrive while the controller is busy are held pending until the controller returns to its waiting state.

## Interface
Parameters:
- DEB_CYCLES, 1_000_000: consecutive stable cycles needed to accept a level change (≥2)
- REPEAT_DELAY, 25_000_000: cycles from the first press pulse to the first repeat pulse (≥2)
- REPEAT_RATE, 5_000_000: cycles between subsequent repeat pulses (≥2)

Ports:
- clk  in  1  system clock
- clr  in  1  reset, asynchronous, active-high
- btn_raw  in  5  raw buttons, bit order {start, down, right, left, rotate}, active-high, asynchronous
- ready  in  1  high when the controller is in its wait-for-input state (its keep output low)
- rotate  out  1  one-cycle command pulse
- left  out  1  one-cycle command pulse
- right  out  1  one-cycle command pulse
- down  out  1  one-cycle command pulse
- start  out  1  one-cycle command pulse
- held  out  5  debounced key levels, same bit order as btn_raw

## Operation
- Synchroniser: each btn_raw bit goes through a 2-flop synchroniser.
- Debounce, per key:
  - Stored level `stable` plus a counter.
  - The counter increments while the synchronised input ≠ stable.
  - The counter clears whenever the two are equal.
  - On the DEB_CYCLES-th consecutive mismatch cycle, stable flips and the counter clears.
  - held = stable.
- Press event: a stable 0→1 transition.
- Auto-repeat (left, right, down only), per key FSM:
  - IDLE → DELAY on a press event.
  - DELAY counts REPEAT_DELAY cycles, emits a repeat event, then → REPEAT.
  - REPEAT emits an event every REPEAT_RATE cycles.
  - stable=0 in any state → IDLE, counter cleared, no event.
  - rotate and start never repeat.
- Pending bits, one per key:
  - Set by any press or repeat event.
  - Several events collapse into one (saturating, no queue).
- Output:
  - When ready=1, each set pending bit produces a 1-cycle pulse on its output and clears in the same edge.
  - When ready=0, no pulses are issued and pending bits persist.
- Left/right conflict: if left and right would pulse in the same cycle, both are suppressed and both pending bits clear.
- Reset: all outputs, held, stable, pending bits, counters and synchronisers go to 0; FSMs go to IDLE.
  - clr mid-press: no pulse is produced after release of reset until a fresh debounced 0→1 transition.

## Timing
- Command outputs are registered; there are no combinational paths from inputs to outputs.
- Press latency with ready=1: a raw rising edge sampled at cycle 0 gives a pulse high in cycle 2+DEB_CYCLES+1, lasting exactly 1 cycle.
- The held rise is 1 cycle before the pulse.
- Repeat pulses (ready=1): the first repeat pulse is REPEAT_DELAY cycles after the press pulse; later ones are spaced REPEAT_RATE cycles apart.
- Release latency: held falls 2+DEB_CYCLES cycles after the raw falling edge.
  - Repeat events stop from the cycle held falls.
  - A pending bit already set still issues its pulse.
- Pending hold: an event while ready=0 pulses in the first cycle ready=1 is sampled, 1 cycle after.
- Bounce: any mismatch run shorter than DEB_CYCLES leaves stable unchanged and produces no pulse.
- Counter widths are $clog2(param+1) bits. Counters never wrap: they clear on terminal count.

## Structure
- Shared package tetris_pkg holds:
  - key index constants KEY_ROTATE=0, KEY_LEFT=1, KEY_RIGHT=2, KEY_DOWN=3, KEY_START=4
  - the repeat FSM state typedef (IDLE, DELAY, REPEAT)
- Sub-module key_debounce contains synchroniser, debounce counter, stable and held output. It is parameterised by DEB_CYCLES and instantiated 5×.
- The top level contains the edge detect, 3 repeat FSMs, pending bits, conflict rule and output registers.

## Test plan
All scenarios use DEB_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8.
- Clean press: rotate raw high at cycle 0 with ready=1 → rotate pulse exactly in cycle 7; held[0] rises in cycle 6; no further pulses while held.
- Bounce: left raw toggles high 3 cycles, low 1, high 3, low → no left pulse; held[1] stays 0.
- Auto-repeat: down held for 60 cycles with ready=1 → pulses at cycles 7, 27, 35, 43, 51, 59; release stops further pulses.
- Busy hold: ready=0 while right is pressed; ready raised at cycle 30 → exactly one right pulse in cycle 31.
- Conflict and reset:
  - left and right raw rise in the same cycle → neither pulses.
  - clr asserted in cycle 5 of a start press → all outputs 0 immediately; no start pulse until release and re-press.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared definitions for the Tetris controller input stage: key bit
// positions and the auto-repeat state encoding.
package tetris_pkg;

  localparam int KEY_ROTATE = 0;
  localparam int KEY_LEFT   = 1;
  localparam int KEY_RIGHT  = 2;
  localparam int KEY_DOWN   = 3;
  localparam int KEY_START  = 4;
  localparam int NUM_KEYS   = 5;

  // Repeat FSM states kept as plain constants so older code that compares
  // against raw encodings keeps working.
  typedef logic [1:0] rpt_state_t;
  localparam rpt_state_t RPT_IDLE   = 2'd0;
  localparam rpt_state_t RPT_DELAY  = 2'd1;
  localparam rpt_state_t RPT_REPEAT = 2'd2;

endpackage

// File: rtl/key_conditioner_if.sv
// Bundle between the key conditioner and the game controller: raw buttons
// and the controller's ready level in, clean command pulses and held levels out.
interface key_conditioner_if;

  logic [4:0] btn_raw;
  logic       ready;
  logic       rotate;
  logic       left;
  logic       right;
  logic       down;
  logic       start;
  logic [4:0] held;

  // The conditioner side produces the commands.
  modport master (
    input  btn_raw,
    input  ready,
    output rotate,
    output left,
    output right,
    output down,
    output start,
    output held
  );

  // The controller side consumes the commands and reports readiness.
  modport slave (
    output btn_raw,
    output ready,
    input  rotate,
    input  left,
    input  right,
    input  down,
    input  start,
    input  held
  );

endinterface

// File: rtl/key_conditioner_debounce.sv
// One button: 2-flop synchroniser followed by a debounce counter that only
// accepts a new level after DEB_CYCLES consecutive disagreeing cycles.
module key_debounce #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic clr,
  input  logic btn_raw_i,
  output logic held_o
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic             stable_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Count disagreeing cycles; flip on the last one, restart on any agreement.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign held_o = stable_q;

endmodule

// File: rtl/key_conditioner.sv
// Tetris input stage: debounces five buttons, turns presses (and auto-repeat
// for left/right/down) into single-cycle command pulses, holding them while
// the controller is busy.
module key_conditioner #(
  parameter int DEB_CYCLES   = 1_000_000,
  parameter int REPEAT_DELAY = 25_000_000,
  parameter int REPEAT_RATE  = 5_000_000
) (
  input logic          clk,
  input logic          clr,
  key_conditioner_if.master bus
);

  import tetris_pkg::*;

  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

  logic [NUM_KEYS-1:0] stable;
  logic [NUM_KEYS-1:0] stablePrev_q;
  logic [NUM_KEYS-1:0] press;
  logic [NUM_KEYS-1:0] repeatEv;
  logic [NUM_KEYS-1:0] events;
  logic [NUM_KEYS-1:0] want;
  logic [NUM_KEYS-1:0] fire;
  logic [NUM_KEYS-1:0] pend_q;
  logic [NUM_KEYS-1:0] pend_d;
  logic [NUM_KEYS-1:0] pulse_q;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : gDeb
    key_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
    ) uDeb (
      .clk       (clk),
      .clr       (clr),
      .btn_raw_i (bus.btn_raw[k]),
      .held_o    (stable[k])
    );
  end

  // Remember last cycle's debounced levels so a 0->1 step can be seen.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      stablePrev_q <= '0;
    end else begin
      stablePrev_q <= stable;
    end
  end

  assign press = stable & ~stablePrev_q;

  assign repeatEv[KEY_ROTATE] = 1'b0;
  assign repeatEv[KEY_START]  = 1'b0;

  for (genvar g = 0; g < 3; g++) begin : gRepeat
    localparam int K = KEY_LEFT + g;

    rpt_state_t       state_q;
    rpt_state_t       state_d;
    logic [RPT_W-1:0] cnt_q;
    logic [RPT_W-1:0] cnt_d;
    logic             ev;

    // Auto-repeat sequencing; a released key drops straight back to idle.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ev      = 1'b0;
      if (!stable[K]) begin
        state_d = RPT_IDLE;
        cnt_d   = '0;
      end else begin
        case (state_q)
          RPT_IDLE: begin
            cnt_d = '0;
            if (press[K]) begin
              state_d = RPT_DELAY;
            end
          end
          RPT_DELAY: begin
            if (cnt_q == DELAY_LAST) begin
              ev      = 1'b1;
              state_d = RPT_REPEAT;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          RPT_REPEAT: begin
            if (cnt_q == RATE_LAST) begin
              ev    = 1'b1;
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          default: begin
            state_d = RPT_IDLE;
            cnt_d   = '0;
          end
        endcase
      end
    end

    // Repeat FSM registers.
    always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
        state_q <= RPT_IDLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    assign repeatEv[K] = ev;
  end

  assign events = press | repeatEv;

  // Decide which commands go out this cycle; left+right together cancel each other.
  always_comb begin
    want = {NUM_KEYS{bus.ready}} & (pend_q | events);
    fire = want;
    if (want[KEY_LEFT] && want[KEY_RIGHT]) begin
      fire[KEY_LEFT]  = 1'b0;
      fire[KEY_RIGHT] = 1'b0;
    end
    pend_d = bus.ready ? '0 : (pend_q | events);
  end

  // Pending bits and the registered command pulses.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pend_q  <= '0;
      pulse_q <= '0;
    end else begin
      pend_q  <= pend_d;
      pulse_q <= fire;
    end
  end

  assign bus.rotate = pulse_q[KEY_ROTATE];
  assign bus.left   = pulse_q[KEY_LEFT];
  assign bus.right  = pulse_q[KEY_RIGHT];
  assign bus.down   = pulse_q[KEY_DOWN];
  assign bus.start  = pulse_q[KEY_START];
  assign bus.held   = stable;

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner with short debounce/repeat timings.
module tb_key_conditioner;

  typedef struct {
    int cyc;
    int key;
  } pulse_t;

  logic clk;
  logic clr;
  int   cyc;
  int   compared;
  int   mismatched;
  int   b;
  pulse_t expQ[$];

  key_conditioner_if bus();

  key_conditioner #(
    .DEB_CYCLES   (4),
    .REPEAT_DELAY (20),
    .REPEAT_RATE  (8)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle index; cycle n is the interval after the n-th edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic stepTo(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expectPulse(input int c, input int k);
    pulse_t p;
    p.cyc = c;
    p.key = k;
    expQ.push_back(p);
  endtask

  // Every observed command pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    logic [4:0] pulses;
    pulse_t p;
    pulses = {bus.start, bus.down, bus.right, bus.left, bus.rotate};
    if (!clr) begin
      for (int k = 0; k < 5; k++) begin
        if (pulses[k]) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected_pulse_key", k, 32'hFFFF_FFFF);
          end else begin
            p = expQ.pop_front();
            checkOutput("pulse_cycle", cyc, p.cyc);
            checkOutput("pulse_key", k, p.key);
          end
        end
      end
    end
  end

  task automatic applyStimulus;
    // Reset state
    clr = 1'b1;
    bus.btn_raw = '0;
    bus.ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_outputs", {bus.start, bus.down, bus.right, bus.left, bus.rotate}, 0);
    checkOutput("reset_held", bus.held, 0);
    clr = 1'b0;
    stepTo(cyc + 5);

    // Clean rotate press
    b = cyc;
    bus.btn_raw[0] = 1'b1;
    expectPulse(b + 7, 0);
    stepTo(b + 5);
    checkOutput("rot_held_before", bus.held[0], 0);
    stepTo(b + 6);
    checkOutput("rot_held_rise", bus.held[0], 1);
    stepTo(b + 40);
    bus.btn_raw[0] = 1'b0;
    stepTo(b + 60);
    checkOutput("rot_sb_drained", expQ.size(), 0);

    // Bouncing left button
    b = cyc;
    bus.btn_raw[1] = 1'b1;
    stepTo(b + 3); bus.btn_raw[1] = 1'b0;
    stepTo(b + 4); bus.btn_raw[1] = 1'b1;
    stepTo(b + 7); bus.btn_raw[1] = 1'b0;
    stepTo(b + 9);
    checkOutput("bounce_held_mid", bus.held[1], 0);
    stepTo(b + 14);
    checkOutput("bounce_held_end", bus.held[1], 0);
    stepTo(b + 30);

    // Down auto-repeat
    b = cyc;
    bus.btn_raw[3] = 1'b1;
    expectPulse(b + 7, 3);
    expectPulse(b + 27, 3);
    expectPulse(b + 35, 3);
    expectPulse(b + 43, 3);
    expectPulse(b + 51, 3);
    expectPulse(b + 59, 3);
    stepTo(b + 60);
    bus.btn_raw[3] = 1'b0;
    stepTo(b + 65);
    checkOutput("down_held_still", bus.held[3], 1);
    stepTo(b + 66);
    checkOutput("down_held_fall", bus.held[3], 0);
    stepTo(b + 100);
    checkOutput("down_sb_drained", expQ.size(), 0);

    // Right press while controller busy
    b = cyc;
    bus.ready = 1'b0;
    bus.btn_raw[2] = 1'b1;
    stepTo(b + 10);
    bus.btn_raw[2] = 1'b0;
    stepTo(b + 30);
    bus.ready = 1'b1;
    expectPulse(b + 31, 2);
    stepTo(b + 50);
    checkOutput("busy_sb_drained", expQ.size(), 0);

    // Left and right together
    b = cyc;
    bus.btn_raw[2:1] = 2'b11;
    stepTo(b + 8);
    checkOutput("conflict_held", bus.held[2:1], 2'b11);
    stepTo(b + 12);
    bus.btn_raw[2:1] = 2'b00;
    stepTo(b + 35);

    // Reset in the middle of a start press, with down already held
    b = cyc;
    bus.btn_raw[3] = 1'b1;
    expectPulse(b + 7, 3);
    stepTo(b + 20);
    bus.btn_raw[4] = 1'b1;
    stepTo(b + 25);
    clr = 1'b1;
    #1;
    checkOutput("clr_outputs", {bus.start, bus.down, bus.right, bus.left, bus.rotate}, 0);
    checkOutput("clr_held", bus.held, 0);
    bus.btn_raw = '0;
    stepTo(b + 28);
    clr = 1'b0;
    stepTo(b + 50);
    checkOutput("clr_held_after", bus.held, 0);
    b = cyc;
    bus.btn_raw[4] = 1'b1;
    expectPulse(b + 7, 4);
    stepTo(b + 15);
    bus.btn_raw[4] = 1'b0;
    stepTo(b + 35);
  endtask

  initial begin
    cyc = 0;
    compared = 0;
    mismatched = 0;
    applyStimulus();
    checkOutput("sb_empty", expQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
